// File: rtl/ma3_pkg.sv
// Shared types and defaults for the ma3 event detector: sample type, event record, FSM states.
package ma3_pkg;

  typedef logic signed [7:0] sample_t;

  localparam sample_t     HiThreshDefault = 8'sd32;
  localparam sample_t     LoThreshDefault = 8'sd16;
  localparam int unsigned LenWDefault     = 8;
  localparam int unsigned DebounceDefault = 3;

  // Record layout at the default duration width, for downstream consumers.
  typedef struct packed {
    sample_t                peak;
    logic [LenWDefault-1:0] len;
  } ev_rec_t;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StArming = 2'd1,
    StActive = 2'd2
  } ma3_state_e;

  function automatic sample_t sample_max(sample_t a, sample_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ma3_event_detector_if.sv
// Sample input, event record output and status bundle of the ma3 event detector.
interface ma3_event_detector_if
  import ma3_pkg::*;
#(
  parameter int unsigned LEN_W = LenWDefault
);

  logic             in_valid;
  sample_t          in_sample;
  logic             ev_valid;
  logic             ev_ready;
  sample_t          ev_peak;
  logic [LEN_W-1:0] ev_len;
  logic             ev_overflow;
  logic             busy;

  modport master (
    output in_valid, in_sample, ev_ready,
    input  ev_valid, ev_peak, ev_len, ev_overflow, busy
  );

  modport slave (
    input  in_valid, in_sample, ev_ready,
    output ev_valid, ev_peak, ev_len, ev_overflow, busy
  );

endinterface

// File: rtl/ma3_event_slot.sv
// One-entry event record register: load, drain, drain+load in one cycle, sticky overflow on drop.
module ma3_event_slot
  import ma3_pkg::*;
#(
  parameter int unsigned LEN_W = LenWDefault
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  sample_t          load_peak_i,
  input  logic [LEN_W-1:0] load_len_i,
  input  logic             ready_i,
  output logic             valid_o,
  output sample_t          peak_o,
  output logic [LEN_W-1:0] len_o,
  output logic             overflow_o
);

  logic             valid_q, valid_d;
  sample_t          peak_q, peak_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             overflow_q, overflow_d;

  always_comb begin
    valid_d    = valid_q;
    peak_d     = peak_q;
    len_d      = len_q;
    overflow_d = overflow_q;
    if (load_i) begin
      // A record being accepted this cycle frees the slot for the new one.
      if (!valid_q || ready_i) begin
        valid_d = 1'b1;
        peak_d  = load_peak_i;
        len_d   = load_len_i;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      peak_q     <= '0;
      len_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      peak_q     <= peak_d;
      len_q      <= len_d;
      overflow_q <= overflow_d;
    end
  end

  assign valid_o    = valid_q;
  assign peak_o     = peak_q;
  assign len_o      = len_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/ma3_event_detector.sv
// Hysteresis excursion detector emitting {peak, len} records over valid/ready.
// Optional debounce on event open is enabled with `define MA3_DEBOUNCE_EN.
module ma3_event_detector
  import ma3_pkg::*;
#(
  parameter sample_t     HI_THRESH = HiThreshDefault,
  parameter sample_t     LO_THRESH = LoThreshDefault,
  parameter int unsigned LEN_W     = LenWDefault,
  parameter int unsigned DEBOUNCE  = DebounceDefault
) (
  input logic                 system1000,
  input logic                 system1000_rst,
  ma3_event_detector_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'(StIdle);
  localparam logic [1:0] ARMING = 2'(StArming);
  localparam logic [1:0] ACTIVE = 2'(StActive);

  if (LO_THRESH > HI_THRESH || DEBOUNCE == 0 || LEN_W == 0) begin : g_param_err
    $error("ma3_event_detector: invalid threshold, debounce or length parameters");
  end

  logic [1:0]       state_q, state_d;
  sample_t          peak_q, peak_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] len_inc;
  logic             close;

`ifdef MA3_DEBOUNCE_EN
  localparam int unsigned DebW = $clog2(DEBOUNCE + 1);

  logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
  logic [DebW:0]   deb_cnt_next;

  assign deb_cnt_next = {1'b0, deb_cnt_q} + (DebW + 1)'(1);
`endif

  assign len_inc = (len_q == '1) ? len_q : len_q + LEN_W'(1);

  always_comb begin
    state_d = state_q;
    peak_d  = peak_q;
    len_d   = len_q;
    close   = 1'b0;
`ifdef MA3_DEBOUNCE_EN
    deb_cnt_d = deb_cnt_q;
`endif
    if (bus.in_valid) begin
      case (state_q)
        IDLE: begin
          if (bus.in_sample >= HI_THRESH) begin
            peak_d = bus.in_sample;
            len_d  = LEN_W'(1);
`ifdef MA3_DEBOUNCE_EN
            deb_cnt_d = DebW'(1);
            state_d   = (DEBOUNCE <= 1) ? ACTIVE : ARMING;
`else
            state_d = ACTIVE;
`endif
          end
        end
`ifdef MA3_DEBOUNCE_EN
        ARMING: begin
          if (bus.in_sample >= HI_THRESH) begin
            peak_d    = sample_max(peak_q, bus.in_sample);
            len_d     = len_inc;
            deb_cnt_d = deb_cnt_next[DebW-1:0];
            if (deb_cnt_next >= (DebW + 1)'(DEBOUNCE)) begin
              state_d = ACTIVE;
            end
          end else begin
            state_d = IDLE;
          end
        end
`endif
        ACTIVE: begin
          if (bus.in_sample >= LO_THRESH) begin
            peak_d = sample_max(peak_q, bus.in_sample);
            len_d  = len_inc;
          end else begin
            // Closing sample is not part of the record.
            close   = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      state_q <= IDLE;
      peak_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      peak_q  <= peak_d;
      len_q   <= len_d;
    end
  end

`ifdef MA3_DEBOUNCE_EN
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      deb_cnt_q <= '0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
    end
  end
`endif

  ma3_event_slot #(
    .LEN_W (LEN_W)
  ) u_slot (
    .clk_i       (system1000),
    .rst_i       (system1000_rst),
    .load_i      (close),
    .load_peak_i (peak_q),
    .load_len_i  (len_q),
    .ready_i     (bus.ev_ready),
    .valid_o     (bus.ev_valid),
    .peak_o      (bus.ev_peak),
    .len_o       (bus.ev_len),
    .overflow_o  (bus.ev_overflow)
  );

  assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_ma3_event_detector.sv
// Directed self-checking bench for ma3_event_detector (default and narrow-length instances).
module tb_ma3_event_detector;
  import ma3_pkg::*;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ma3_event_detector_if #(.LEN_W(8)) bus ();
  ma3_event_detector_if #(.LEN_W(4)) bus4 ();

  ma3_event_detector #(
    .HI_THRESH (8'sd32),
    .LO_THRESH (8'sd16),
    .LEN_W     (8),
    .DEBOUNCE  (1)
  ) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .bus            (bus.slave)
  );

  ma3_event_detector #(
    .HI_THRESH (8'sd32),
    .LO_THRESH (8'sd16),
    .LEN_W     (4),
    .DEBOUNCE  (1)
  ) dut4 (
    .system1000     (clk),
    .system1000_rst (rst),
    .bus            (bus4.slave)
  );

`ifdef MA3_DEBOUNCE_EN
  ma3_event_detector_if #(.LEN_W(8)) busd ();

  ma3_event_detector #(
    .HI_THRESH (8'sd32),
    .LO_THRESH (8'sd16),
    .LEN_W     (8),
    .DEBOUNCE  (3)
  ) dutd (
    .system1000     (clk),
    .system1000_rst (rst),
    .bus            (busd.slave)
  );

  task automatic sendd(input logic v, input int s);
    busd.in_valid  = v;
    busd.in_sample = 8'(s);
    @(posedge clk);
    #1;
  endtask
`endif

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input; outputs reflect this sample on return.
  task automatic send(input logic v, input int s);
    bus.in_valid  = v;
    bus.in_sample = 8'(s);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_sample  = '0;
    bus.ev_ready   = 1'b1;
    bus4.in_valid  = 1'b0;
    bus4.in_sample = '0;
    bus4.ev_ready  = 1'b1;
`ifdef MA3_DEBOUNCE_EN
    busd.in_valid  = 1'b0;
    busd.in_sample = '0;
    busd.ev_ready  = 1'b1;
`endif
    send(0, 0);
    send(0, 0);
    check("rst_ev_valid", bus.ev_valid, 0);
    check("rst_ev_peak", bus.ev_peak, 0);
    check("rst_ev_len", bus.ev_len, 0);
    check("rst_ev_overflow", bus.ev_overflow, 0);
    check("rst_busy", bus.busy, 0);
    rst = 1'b0;

    // Basic event: 0,40,50,45,20,10
    send(1, 0);
    check("t1_busy_idle", bus.busy, 0);
    send(1, 40);
    check("t1_busy_open", bus.busy, 1);
    check("t1_no_valid_open", bus.ev_valid, 0);
    send(1, 50);
    send(1, 45);
    send(1, 20);
    check("t1_busy_hyst", bus.busy, 1);
    send(1, 10);
    check("t1_ev_valid", bus.ev_valid, 1);
    check("t1_ev_peak", bus.ev_peak, 50);
    check("t1_ev_len", bus.ev_len, 4);
    check("t1_busy_closed", bus.busy, 0);
    send(0, 0);
    check("t1_valid_one_cycle", bus.ev_valid, 0);

    // Bubbles ignored: 40,-,20,-,10
    send(1, 40);
    send(0, 99);
    check("t2_busy_bubble", bus.busy, 1);
    send(1, 20);
    send(0, 0);
    send(1, 10);
    check("t2_ev_valid", bus.ev_valid, 1);
    check("t2_ev_peak", bus.ev_peak, 40);
    check("t2_ev_len", bus.ev_len, 2);
    send(0, 0);
    check("t2_valid_drop", bus.ev_valid, 0);

    // Overflow: ready low, two events
    bus.ev_ready = 1'b0;
    send(1, 60);
    send(1, 10);
    send(1, 70);
    send(1, 10);
    check("t3_ev_valid", bus.ev_valid, 1);
    check("t3_ev_peak_held", bus.ev_peak, 60);
    check("t3_ev_len_held", bus.ev_len, 1);
    check("t3_overflow", bus.ev_overflow, 1);
    bus.ev_ready = 1'b1;
    send(0, 0);
    check("t3_drained", bus.ev_valid, 0);
    check("t3_overflow_sticky", bus.ev_overflow, 1);

    rst = 1'b1;
    send(0, 0);
    rst = 1'b0;
    check("t4_overflow_cleared", bus.ev_overflow, 0);

    // Drain and load in the same cycle
    bus.ev_ready = 1'b0;
    send(1, 60);
    send(1, 10);
    send(1, 70);
    send(1, 80);
    bus.ev_ready = 1'b1;
    check("t4_first_offered_valid", bus.ev_valid, 1);
    check("t4_first_offered_peak", bus.ev_peak, 60);
    send(1, 10);
    check("t4_second_valid", bus.ev_valid, 1);
    check("t4_second_peak", bus.ev_peak, 80);
    check("t4_second_len", bus.ev_len, 2);
    check("t4_no_overflow", bus.ev_overflow, 0);
    send(0, 0);
    check("t4_drained", bus.ev_valid, 0);

    // Back-to-back: close then open on the next sample
    send(1, 40);
    send(1, 10);
    check("t5_first_peak", bus.ev_peak, 40);
    send(1, 50);
    check("t5_reopen_busy", bus.busy, 1);
    check("t5_first_accepted", bus.ev_valid, 0);
    send(1, 10);
    check("t5_second_valid", bus.ev_valid, 1);
    check("t5_second_peak", bus.ev_peak, 50);
    check("t5_second_len", bus.ev_len, 1);
    send(0, 0);

    // Saturation on the 4-bit length instance
    for (int i = 0; i < 20; i++) begin
      bus4.in_valid  = 1'b1;
      bus4.in_sample = 8'sd40;
      @(posedge clk);
      #1;
    end
    bus4.in_sample = 8'sd0;
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    check("t6_sat_valid", bus4.ev_valid, 1);
    check("t6_sat_len", bus4.ev_len, 15);
    check("t6_sat_peak", bus4.ev_peak, 40);

    // Short excursion 40,40,10
`ifdef MA3_DEBOUNCE_EN
    sendd(1, 40);
    check("t7_arming_busy", busd.busy, 1);
    sendd(1, 40);
    sendd(1, 10);
    check("t7_abort_busy", busd.busy, 0);
    check("t7_abort_no_rec", busd.ev_valid, 0);
    sendd(1, 40);
    sendd(1, 40);
    sendd(1, 40);
    check("t7_active_busy", busd.busy, 1);
    sendd(1, 0);
    check("t7_deb_valid", busd.ev_valid, 1);
    check("t7_deb_len", busd.ev_len, 3);
    check("t7_deb_peak", busd.ev_peak, 40);
    sendd(0, 0);
`else
    send(1, 40);
    send(1, 40);
    send(1, 10);
    check("t7_short_valid", bus.ev_valid, 1);
    check("t7_short_len", bus.ev_len, 2);
    check("t7_short_busy", bus.busy, 0);
    send(0, 0);
`endif

    // Reset mid-event discards open event and pending record
    bus.ev_ready = 1'b0;
    send(1, 40);
    send(1, 10);
    send(1, 50);
    check("t8_pending", bus.ev_valid, 1);
    check("t8_open", bus.busy, 1);
    rst = 1'b1;
    send(1, 60);
    rst = 1'b0;
    check("t8_rst_valid", bus.ev_valid, 0);
    check("t8_rst_busy", bus.busy, 0);
    send(1, 10);
    check("t8_no_stale_close", bus.ev_valid, 0);
    send(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
